// File: rtl/branch_tag_allocator_pkg.sv
// Shared types for the branch-tag allocator: tag mask type, lane grant packet and helpers.
// `B_MASK_WIDTH may be overridden on the command line; it defaults to 4 tags.
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package branch_tag_allocator_pkg;

  localparam int B_MASK_WIDTH   = `B_MASK_WIDTH;
  localparam int DISPATCH_WIDTH = 2;

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;

  typedef struct packed {
    logic  valid;
    B_MASK tag;
    B_MASK dep_mask;
  } BTAG_GRANT_PACKET;

  // Isolates the lowest set bit, giving the one-hot of the lowest free tag.
  function automatic B_MASK lowest_one(input B_MASK v);
    return v & (~v + B_MASK'(1));
  endfunction

endpackage

// File: rtl/btag_free_select.sv
// Lowest-first one-hot tag selector across dispatch lanes; a requesting lane that
// misses a tag blocks every younger lane so grants always form an in-order prefix.
module btag_free_select
  import branch_tag_allocator_pkg::*;
(
  input  logic                                   enable_i,
  input  B_MASK                                  free_i,
  input  logic [DISPATCH_WIDTH-1:0]              req_i,
  output logic [DISPATCH_WIDTH-1:0]              grant_o,
  output B_MASK [DISPATCH_WIDTH-1:0]             tag_o
);

  B_MASK avail;
  logic  blocked;

  always_comb begin
    avail   = free_i;
    blocked = 1'b0;
    grant_o = '0;
    tag_o   = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (req_i[k] && !blocked) begin
        if (enable_i && avail != '0) begin
          tag_o[k]   = lowest_one(avail);
          grant_o[k] = 1'b1;
          avail      = avail & ~tag_o[k];
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch-tag pool: grants tags at dispatch, tracks per-tag dependency masks, clears and squashes.
// Define BTAG_STATS_EN to add saturating stall-cycle and squashed-tag counters.
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
(
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [DISPATCH_WIDTH-1:0]                br_req,
  output logic [DISPATCH_WIDTH-1:0]                br_grant,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   br_tag,
  output logic [DISPATCH_WIDTH*B_MASK_WIDTH-1:0]   br_dep_mask,
  output logic                                     dispatch_stall,
  input  logic                                     resolve_valid,
  input  B_MASK                                    resolve_tag,
  input  logic                                     resolve_mispred,
  output B_MASK                                    clear_mask,
  output B_MASK                                    squash_mask,
  output B_MASK                                    active_mask
`ifdef BTAG_STATS_EN
  ,
  output logic [31:0]                              stat_stall_cycles,
  output logic [31:0]                              stat_squash_tags
`endif
);

  B_MASK                           active_q, active_d;
  B_MASK [B_MASK_WIDTH-1:0]        dep_q, dep_d;
  logic                            resolve_legal, mispred;
  B_MASK                           kill;
  logic [DISPATCH_WIDTH-1:0]       sel_grant;
  B_MASK [DISPATCH_WIDTH-1:0]      sel_tag;
  BTAG_GRANT_PACKET                lane [DISPATCH_WIDTH];
  B_MASK                           older;

  // Resolves naming a tag outside the active set are dropped.
  assign resolve_legal = resolve_valid && !reset && (resolve_tag != '0) &&
                         ((resolve_tag & ~active_q) == '0);
  assign mispred       = resolve_legal && resolve_mispred;

  always_comb begin
    squash_mask = '0;
    if (mispred) begin
      squash_mask = resolve_tag;
      for (int i = 0; i < B_MASK_WIDTH; i++) begin
        if ((dep_q[i] & resolve_tag) != '0) squash_mask[i] = 1'b1;
      end
    end
  end

  assign clear_mask = (resolve_legal && !resolve_mispred) ? resolve_tag : '0;
  assign kill       = clear_mask | squash_mask;

  btag_free_select u_select (
    .enable_i (!reset && !mispred),
    .free_i   (~active_q),
    .req_i    (br_req),
    .grant_o  (sel_grant),
    .tag_o    (sel_tag)
  );

  // Each lane's dependency mask sees same-cycle resolves and older lanes' fresh tags.
  always_comb begin
    older = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      lane[k].valid    = sel_grant[k];
      lane[k].tag      = sel_tag[k];
      lane[k].dep_mask = sel_grant[k] ? ((active_q & ~kill) | older) : '0;
      older            = older | sel_tag[k];
      br_grant[k]                                  = lane[k].valid;
      br_tag[k*B_MASK_WIDTH +: B_MASK_WIDTH]       = lane[k].tag;
      br_dep_mask[k*B_MASK_WIDTH +: B_MASK_WIDTH]  = lane[k].dep_mask;
    end
  end

  assign dispatch_stall = !reset && ((br_req & ~sel_grant) != '0);
  assign active_mask    = active_q;

  always_comb begin
    active_d = active_q & ~kill;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      dep_d[i] = kill[i] ? '0 : (dep_q[i] & ~kill);
    end
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (lane[k].valid) begin
        active_d = active_d | lane[k].tag;
        for (int i = 0; i < B_MASK_WIDTH; i++) begin
          if (lane[k].tag[i]) dep_d[i] = lane[k].dep_mask;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= '0;
      dep_q    <= '0;
    end else begin
      active_q <= active_d;
      dep_q    <= dep_d;
    end
  end

  illegal_resolve_tag: assert property (@(posedge clock) disable iff (reset)
    resolve_valid |-> (resolve_tag != '0 && (resolve_tag & ~active_q) == '0));

`ifdef BTAG_STATS_EN
  logic [31:0] stall_cnt_q, squash_cnt_q;
  logic [32:0] squash_sum;

  assign squash_sum = {1'b0, squash_cnt_q} + 33'($countones(squash_mask));

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (dispatch_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      squash_cnt_q <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_squash_tags  = squash_cnt_q;
`endif

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Directed scoreboard bench for branch_tag_allocator (4 tags, 2 lanes); also checks
// the stats counters when BTAG_STATS_EN is defined.
module tb_branch_tag_allocator;
  import branch_tag_allocator_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  br_req = '0;
  logic [1:0]  br_grant;
  logic [7:0]  br_tag, br_dep_mask;
  logic        dispatch_stall;
  logic        resolve_valid = 1'b0;
  logic [3:0]  resolve_tag = '0;
  logic        resolve_mispred = 1'b0;
  logic [3:0]  clear_mask, squash_mask, active_mask;
`ifdef BTAG_STATS_EN
  logic [31:0] stat_stall_cycles, stat_squash_tags;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [1:0] grant;
    logic [7:0] tag;
    logic [7:0] dep;
    logic       stall;
    logic [3:0] clear;
    logic [3:0] squash;
    logic [3:0] active_next;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  branch_tag_allocator dut (
    .clock           (clock),
    .reset           (reset),
    .br_req          (br_req),
    .br_grant        (br_grant),
    .br_tag          (br_tag),
    .br_dep_mask     (br_dep_mask),
    .dispatch_stall  (dispatch_stall),
    .resolve_valid   (resolve_valid),
    .resolve_tag     (resolve_tag),
    .resolve_mispred (resolve_mispred),
    .clear_mask      (clear_mask),
    .squash_mask     (squash_mask),
    .active_mask     (active_mask)
`ifdef BTAG_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_squash_tags  (stat_squash_tags)
`endif
  );

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic rst, input logic [1:0] req,
                               input logic rv, input logic [3:0] rtag, input logic rmis,
                               input logic [1:0] g, input logic [7:0] t, input logic [7:0] d,
                               input logic st, input logic [3:0] cl, input logic [3:0] sq,
                               input logic [3:0] act);
    exp_t e;
    @(negedge clock);
    reset           = rst;
    br_req          = req;
    resolve_valid   = rv;
    resolve_tag     = rtag;
    resolve_mispred = rmis;
    e.name = name; e.grant = g; e.tag = t; e.dep = d; e.stall = st;
    e.clear = cl; e.squash = sq; e.active_next = act;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      checkField({e.name, ".grant"},  32'(br_grant),       32'(e.grant));
      checkField({e.name, ".tag"},    32'(br_tag),         32'(e.tag));
      checkField({e.name, ".dep"},    32'(br_dep_mask),    32'(e.dep));
      checkField({e.name, ".stall"},  32'(dispatch_stall), 32'(e.stall));
      checkField({e.name, ".clear"},  32'(clear_mask),     32'(e.clear));
      checkField({e.name, ".squash"}, 32'(squash_mask),    32'(e.squash));
      @(posedge clock);
      #1;
      checkField({e.name, ".active"}, 32'(active_mask),    32'(e.active_next));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            name          rst req  rv rtag     mis  grant  tag    dep    st cl       sq       active
    applyStimulus("reset",      1, 2'b00, 0, 4'b0000, 0, 2'b00, 8'h00, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000); checkOutput();
    applyStimulus("alloc2",     0, 2'b11, 0, 4'b0000, 0, 2'b11, 8'h21, 8'h10, 0, 4'b0000, 4'b0000, 4'b0011); checkOutput();
    applyStimulus("clr_alloc",  0, 2'b01, 1, 4'b0001, 0, 2'b01, 8'h04, 8'h02, 0, 4'b0001, 4'b0000, 4'b0110); checkOutput();
    applyStimulus("realloc0",   0, 2'b01, 0, 4'b0000, 0, 2'b01, 8'h01, 8'h06, 0, 4'b0000, 4'b0000, 4'b0111); checkOutput();
    applyStimulus("mis_young",  0, 2'b11, 1, 4'b0001, 1, 2'b00, 8'h00, 8'h00, 1, 4'b0000, 4'b0001, 4'b0110); checkOutput();
    applyStimulus("fill",       0, 2'b11, 0, 4'b0000, 0, 2'b11, 8'h81, 8'h76, 0, 4'b0000, 4'b0000, 4'b1111); checkOutput();
    applyStimulus("full",       0, 2'b11, 0, 4'b0000, 0, 2'b00, 8'h00, 8'h00, 1, 4'b0000, 4'b0000, 4'b1111); checkOutput();
    applyStimulus("full_clr",   0, 2'b01, 1, 4'b0010, 0, 2'b00, 8'h00, 8'h00, 1, 4'b0010, 4'b0000, 4'b1101); checkOutput();
    applyStimulus("reuse",      0, 2'b01, 0, 4'b0000, 0, 2'b01, 8'h02, 8'h0D, 0, 4'b0000, 4'b0000, 4'b1111); checkOutput();
    applyStimulus("clr0",       0, 2'b00, 1, 4'b0001, 0, 2'b00, 8'h00, 8'h00, 0, 4'b0001, 4'b0000, 4'b1110); checkOutput();
    applyStimulus("partial",    0, 2'b11, 0, 4'b0000, 0, 2'b01, 8'h01, 8'h0E, 1, 4'b0000, 4'b0000, 4'b1111); checkOutput();
    applyStimulus("mis_all",    0, 2'b00, 1, 4'b0100, 1, 2'b00, 8'h00, 8'h00, 0, 4'b0000, 4'b1111, 4'b0000); checkOutput();
    applyStimulus("alloc2b",    0, 2'b11, 0, 4'b0000, 0, 2'b11, 8'h21, 8'h10, 0, 4'b0000, 4'b0000, 4'b0011); checkOutput();
    applyStimulus("alloc_t2",   0, 2'b01, 0, 4'b0000, 0, 2'b01, 8'h04, 8'h03, 0, 4'b0000, 4'b0000, 4'b0111); checkOutput();
    applyStimulus("mis_old",    0, 2'b01, 1, 4'b0001, 1, 2'b00, 8'h00, 8'h00, 1, 4'b0000, 4'b0111, 4'b0000); checkOutput();
    applyStimulus("alloc2c",    0, 2'b11, 0, 4'b0000, 0, 2'b11, 8'h21, 8'h10, 0, 4'b0000, 4'b0000, 4'b0011); checkOutput();
    applyStimulus("rst_mis",    1, 2'b11, 1, 4'b0001, 1, 2'b00, 8'h00, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000); checkOutput();
    applyStimulus("post_rst",   0, 2'b00, 0, 4'b0000, 0, 2'b00, 8'h00, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000);
`ifdef BTAG_STATS_EN
    #1;
    checkField("stats.stall_after_reset",  stat_stall_cycles, 32'd0);
    checkField("stats.squash_after_reset", stat_squash_tags,  32'd0);
`endif
    checkOutput();
    applyStimulus("lane1_only", 0, 2'b10, 0, 4'b0000, 0, 2'b10, 8'h10, 8'h00, 0, 4'b0000, 4'b0000, 4'b0001); checkOutput();
    applyStimulus("lane1_dep",  0, 2'b10, 0, 4'b0000, 0, 2'b10, 8'h20, 8'h10, 0, 4'b0000, 4'b0000, 4'b0011); checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
